// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding and default width.
package pwm_capture_pkg;

   localparam int unsigned DefaultWidth = 8;

   // Encoding matches the ST_SEEK/ST_MEASURE values used by the pwmN bench.
   typedef enum logic {
      StSeek    = 1'b0,
      StMeasure = 1'b1
   } pwm_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM input plus a delay flop for rising-edge
// detection. Outputs the synchronized level and a single-cycle rise pulse.
module pwm_edge_sync
   import pwm_capture_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  logic pwm_in,
   output logic s2,
   output logic rise
);

   logic s1_q;
   logic s2_q;
   logic s3_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= pwm_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign s2   = s2_q;
   assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM signal between successive rising edges,
// publishing each measurement with a valid strobe and flagging a stuck line via timeout.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int unsigned N = DefaultWidth
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         pwm_in,
   output logic [N-1:0] duty,
   output logic [N-1:0] period,
   output logic         valid,
   output logic         timeout,
   output logic         level
);

   localparam logic [N-1:0] Max = {N{1'b1}};
   localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

   logic sync_lvl;
   logic rise;

   pwm_edge_sync u_edge_sync (
      .clk    (clk),
      .clr    (clr),
      .pwm_in (pwm_in),
      .s2     (sync_lvl),
      .rise   (rise)
   );

   pwm_state_e   state_q, state_d;
   logic [N-1:0] cnt_p_q, cnt_p_d;
   logic [N-1:0] cnt_h_q, cnt_h_d;
   logic [N-1:0] duty_q, duty_d;
   logic [N-1:0] period_q, period_d;
   logic         valid_q, valid_d;
   logic         timeout_q, timeout_d;
   logic         level_q, level_d;

   always_comb begin
      state_d   = state_q;
      cnt_p_d   = cnt_p_q;
      cnt_h_d   = cnt_h_q;
      duty_d    = duty_q;
      period_d  = period_q;
      level_d   = level_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;

      if (rise) begin
         // A rise always restarts counting; it only reports once a reference edge exists.
         cnt_p_d = One;
         cnt_h_d = One;
         state_d = StMeasure;
         if (state_q == StMeasure) begin
            duty_d   = cnt_h_q;
            period_d = cnt_p_q;
            valid_d  = 1'b1;
         end
      end else begin
         if (sync_lvl && (cnt_h_q != Max)) begin
            cnt_h_d = cnt_h_q + One;
         end
         if (cnt_p_q == Max) begin
            // Restarting from zero makes the timeout re-fire while the line stays stuck.
            timeout_d = 1'b1;
            level_d   = sync_lvl;
            state_d   = StSeek;
            cnt_p_d   = '0;
         end else begin
            cnt_p_d = cnt_p_q + One;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= StSeek;
         cnt_p_q   <= '0;
         cnt_h_q   <= '0;
         duty_q    <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         level_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_p_q   <= cnt_p_d;
         cnt_h_q   <= cnt_h_d;
         duty_q    <= duty_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         level_q   <= level_d;
      end
   end

   assign duty    = duty_q;
   assign period  = period_q;
   assign valid   = valid_q;
   assign timeout = timeout_q;
   assign level   = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: scenario tasks compare the DUT each cycle against a
// behavioural measurement model and against scenario-level expectations.
module tb_pwm_capture;

   localparam int N   = 8;
   localparam int MAX = 255;

   logic         clk = 1'b0;
   logic         clr = 1'b1;
   logic         pwm_in = 1'b0;
   logic [N-1:0] duty;
   logic [N-1:0] period;
   logic         valid;
   logic         timeout;
   logic         level;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pwm_capture #(.N(N)) dut (
      .clk     (clk),
      .clr     (clr),
      .pwm_in  (pwm_in),
      .duty    (duty),
      .period  (period),
      .valid   (valid),
      .timeout (timeout),
      .level   (level)
   );

   // Reference model: pin samples delayed through a short history, then measurement rules
   // applied to the synchronized waveform.
   logic         m_hist [3];
   int           m_since;
   int           m_highs;
   bit           m_locked;
   logic [N-1:0] m_duty;
   logic [N-1:0] m_period;
   logic         m_valid;
   logic         m_timeout;
   logic         m_level;

   function automatic void model_step();
      logic lvl;
      logic rise;
      if (clr) begin
         m_hist[0] = 1'b0; m_hist[1] = 1'b0; m_hist[2] = 1'b0;
         m_since = 0; m_highs = 0; m_locked = 0;
         m_duty = '0; m_period = '0; m_valid = 1'b0; m_timeout = 1'b0; m_level = 1'b0;
      end else begin
         lvl  = m_hist[1];
         rise = m_hist[1] && !m_hist[2];
         m_valid = 1'b0;
         m_timeout = 1'b0;
         if (rise) begin
            if (m_locked) begin
               m_duty   = 8'(m_highs);
               m_period = 8'(m_since);
               m_valid  = 1'b1;
            end
            m_locked = 1;
            m_since  = 1;
            m_highs  = 1;
         end else begin
            if (lvl) m_highs = (m_highs + 1 > MAX) ? MAX : m_highs + 1;
            if (m_since == MAX) begin
               m_timeout = 1'b1;
               m_level   = lvl;
               m_locked  = 0;
               m_since   = 0;
            end else begin
               m_since = m_since + 1;
            end
         end
         m_hist[2] = m_hist[1];
         m_hist[1] = m_hist[0];
         m_hist[0] = pwm_in;
      end
   endfunction

   task automatic step(input logic p, input logic c);
      pwm_in = p;
      clr    = c;
      @(negedge clk);
      model_step();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(i[0], 1'b1);
         checks++;
         if ({valid, timeout, level, duty, period} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {valid, timeout, level, duty, period});
         end
      end
   endtask

   task automatic test_steady();
      int valids = 0;
      for (int r = 0; r < 6 + 1; r++) begin
         for (int i = 0; i < 8; i++) begin
            step((r < 6) && (i < 3), 1'b0);
            checks++;
            if ({valid, timeout, level, duty, period} !==
                {m_valid, m_timeout, m_level, m_duty, m_period}) begin
               failures++;
               $display("FAIL steady_cycle got=%h exp=%h", {valid, timeout, level, duty, period},
                        {m_valid, m_timeout, m_level, m_duty, m_period});
            end
            if (valid) begin
               valids++;
               checks++;
               if (duty !== 8'd3 || period !== 8'd8) begin
                  failures++;
                  $display("FAIL steady_meas duty=%0d period=%0d exp duty=3 period=8",
                           duty, period);
               end
            end
         end
      end
      checks++;
      if (valids !== 5) begin
         failures++;
         $display("FAIL steady_valid_count got=%0d exp=5", valids);
      end
   endtask

   task automatic test_random();
      int unsigned q_hi [$];
      int unsigned q_lo [$];
      int unsigned hi, lo, ehi, elo;
      step(1'b0, 1'b1);
      for (int p = 0; p < 25; p++) begin
         hi = $urandom_range(20, 1);
         lo = $urandom_range(20, 2);
         q_hi.push_back(hi);
         q_lo.push_back(lo);
         for (int i = 0; i < int'(hi + lo); i++) begin
            step(i < int'(hi), 1'b0);
            checks++;
            if ({valid, timeout, level, duty, period} !==
                {m_valid, m_timeout, m_level, m_duty, m_period}) begin
               failures++;
               $display("FAIL random_cycle got=%h exp=%h", {valid, timeout, level, duty, period},
                        {m_valid, m_timeout, m_level, m_duty, m_period});
            end
            if (valid) begin
               ehi = q_hi.pop_front();
               elo = q_lo.pop_front();
               checks++;
               if (duty !== 8'(ehi) || period !== 8'(ehi + elo)) begin
                  failures++;
                  $display("FAIL random_meas duty=%0d period=%0d exp duty=%0d period=%0d",
                           duty, period, ehi, ehi + elo);
               end
            end
         end
      end
   endtask

   task automatic test_loopback();
      int sets [3];
      int q_d [$];
      int valids = 0;
      int ed;
      sets[0] = 10; sets[1] = 128; sets[2] = 254;
      step(1'b0, 1'b1);
      for (int s = 0; s < 3; s++) begin
         for (int p = 0; p < 3; p++) begin
            q_d.push_back(sets[s]);
            for (int i = 0; i < MAX; i++) begin
               step(i < sets[s], 1'b0);
               checks++;
               if ({valid, timeout, level, duty, period} !==
                   {m_valid, m_timeout, m_level, m_duty, m_period}) begin
                  failures++;
                  $display("FAIL loop_cycle got=%h exp=%h", {valid, timeout, level, duty, period},
                           {m_valid, m_timeout, m_level, m_duty, m_period});
               end
               if (valid) begin
                  valids++;
                  ed = q_d.pop_front();
                  checks++;
                  if (period !== 8'd255 || int'(duty) < ed - 1 || int'(duty) > ed + 1) begin
                     failures++;
                     $display("FAIL loop_meas duty=%0d period=%0d exp duty=%0d+/-1 period=255",
                              duty, period, ed);
                  end
               end
            end
         end
      end
      checks++;
      if (valids !== 8) begin
         failures++;
         $display("FAIL loop_valid_count got=%0d exp=8", valids);
      end
   endtask

   task automatic test_stuck_high();
      int touts = 0;
      int valids = 0;
      step(1'b0, 1'b1);
      for (int i = 0; i < 24 + 700; i++) begin
         step((i >= 24) || (i % 8 < 4), 1'b0);
         checks++;
         if ({valid, timeout, level, duty, period} !==
             {m_valid, m_timeout, m_level, m_duty, m_period}) begin
            failures++;
            $display("FAIL stuckhi_cycle got=%h exp=%h", {valid, timeout, level, duty, period},
                     {m_valid, m_timeout, m_level, m_duty, m_period});
         end
         if (i >= 30 && valid) valids++;
         if (timeout) begin
            touts++;
            checks++;
            if (level !== 1'b1 || valid !== 1'b0) begin
               failures++;
               $display("FAIL stuckhi_level level=%0b valid=%0b exp level=1 valid=0",
                        level, valid);
            end
         end
      end
      checks++;
      if (touts < 2 || valids != 0) begin
         failures++;
         $display("FAIL stuckhi_counts timeouts=%0d valids=%0d exp timeouts>=2 valids=0",
                  touts, valids);
      end
      valids = 0;
      for (int i = 0; i < 4 + 32 + 4; i++) begin
         step((i >= 4) && (i < 36) && ((i - 4) % 8 < 4), 1'b0);
         checks++;
         if ({valid, timeout, level, duty, period} !==
             {m_valid, m_timeout, m_level, m_duty, m_period}) begin
            failures++;
            $display("FAIL resume_cycle got=%h exp=%h", {valid, timeout, level, duty, period},
                     {m_valid, m_timeout, m_level, m_duty, m_period});
         end
         if (valid) begin
            valids++;
            checks++;
            if (duty !== 8'd4 || period !== 8'd8) begin
               failures++;
               $display("FAIL resume_meas duty=%0d period=%0d exp duty=4 period=8",
                        duty, period);
            end
         end
      end
      checks++;
      if (valids !== 3) begin
         failures++;
         $display("FAIL resume_valid_count got=%0d exp=3", valids);
      end
   endtask

   task automatic test_stuck_low();
      int touts = 0;
      step(1'b0, 1'b1);
      for (int i = 0; i < 600; i++) begin
         step(1'b0, 1'b0);
         checks++;
         if ({valid, timeout, level, duty, period} !==
             {m_valid, m_timeout, m_level, m_duty, m_period}) begin
            failures++;
            $display("FAIL stucklo_cycle got=%h exp=%h", {valid, timeout, level, duty, period},
                     {m_valid, m_timeout, m_level, m_duty, m_period});
         end
         if (timeout) begin
            touts++;
            checks++;
            if (level !== 1'b0 || duty !== 8'd0 || period !== 8'd0) begin
               failures++;
               $display("FAIL stucklo_out level=%0b duty=%0d period=%0d exp all 0",
                        level, duty, period);
            end
         end
      end
      checks++;
      if (touts < 2) begin
         failures++;
         $display("FAIL stucklo_count timeouts=%0d exp>=2", touts);
      end
   endtask

   task automatic test_clr_mid();
      int valids = 0;
      step(1'b0, 1'b1);
      for (int i = 0; i < 32; i++) step(i % 10 < 4, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      checks++;
      if ({valid, timeout, level, duty, period} !== 27'd0) begin
         failures++;
         $display("FAIL clrmid_outputs got=%h exp=0", {valid, timeout, level, duty, period});
      end
      for (int i = 0; i < 3 + 24 + 4; i++) begin
         step((i >= 3) && (i < 27) && ((i - 3) % 8 < 5), 1'b0);
         checks++;
         if ({valid, timeout, level, duty, period} !==
             {m_valid, m_timeout, m_level, m_duty, m_period}) begin
            failures++;
            $display("FAIL clrmid_cycle got=%h exp=%h", {valid, timeout, level, duty, period},
                     {m_valid, m_timeout, m_level, m_duty, m_period});
         end
         if (valid) begin
            valids++;
            checks++;
            if (duty !== 8'd5 || period !== 8'd8) begin
               failures++;
               $display("FAIL clrmid_meas duty=%0d period=%0d exp duty=5 period=8",
                        duty, period);
            end
         end
      end
      checks++;
      if (valids !== 2) begin
         failures++;
         $display("FAIL clrmid_valid_count got=%0d exp=2", valids);
      end
   endtask

   initial begin
      test_reset();
      test_steady();
      test_random();
      test_loopback();
      test_stuck_high();
      test_stuck_low();
      test_clr_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
